// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-to-RAM command sequencer.
// Holds the command-word field positions, opcode encodings, the sequencer
// state encoding and burst-length limits.
package spi_ram_pkg;

    localparam int DATA_W  = 16;
    localparam int MAX_LEN = 64;
    // Remaining-count register must hold MAX_LEN itself, not just MAX_LEN-1.
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    // Command word layout: [15:14] op, [13:8] len-1, [7:0] start address.
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 14;
    localparam int LEN_HI  = 13;
    localparam int LEN_LO  = 8;
    localparam int ADDR_HI = 7;
    localparam int ADDR_LO = 0;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_ILL   = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_DATA  = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_PUSH  = 3'd4
    } state_t;

endpackage

// File: rtl/spi_ram_cmd_controller_if.sv
// Bus bundle around the command sequencer.
// Carries the deserialized word stream and chip-select level, the single-port
// RAM access port, the transmit handshake toward the SPI shifter and the
// status/error flags.
//   master : the sequencer's view (drives RAM port, tx side, status)
//   slave  : the surrounding system's view (deserializer, RAM, shifter, CSR)
interface spi_ram_cmd_controller_if #(
    parameter int ADDR_W = 8
);
    import spi_ram_pkg::*;

    logic [DATA_W-1:0] word_in;
    logic              word_valid;
    logic              cs_active;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] tx_word;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;
    logic              err_abort;
    logic              err_cmd;
    logic              clr_err;

    modport master (
        input  word_in, word_valid, cs_active, ram_rdata, tx_ready, clr_err,
        output ram_en, ram_we, ram_addr, ram_wdata, tx_word, tx_valid,
               busy, done, err_abort, err_cmd
    );

    modport slave (
        output word_in, word_valid, cs_active, ram_rdata, tx_ready, clr_err,
        input  ram_en, ram_we, ram_addr, ram_wdata, tx_word, tx_valid,
               busy, done, err_abort, err_cmd
    );

endinterface

// File: rtl/spi_ram_cmd_controller.sv
// Command sequencer between the SPI word deserializer and a single-port RAM.
// The first word of a frame is decoded as a command; WRITE bursts store the
// following words, READ bursts fetch words and hand them to the transmit
// shifter over a valid/ready handshake.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : spi_ram_cmd_controller_if.master (word stream, RAM, tx, status)
module spi_ram_cmd_controller
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    spi_ram_cmd_controller_if.master          bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_pend_q, wr_pend_d;
    logic              wr_last_q, wr_last_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] tx_word_q, tx_word_d;
    logic              tx_valid_q, tx_valid_d;
    logic              err_abort_q, err_abort_d;
    logic              err_cmd_q, err_cmd_d;

    op_t  cmd_op;
    logic abort;
    logic issue_wr;
    logic issue_rd;
    logic done_c;

    always_comb begin
        cmd_op   = op_t'(bus.word_in[OP_HI:OP_LO]);
        // Chip-select loss outside IDLE overrides everything else this cycle.
        abort    = (state_q != IDLE) && !bus.cs_active;
        // Gating with reset keeps the RAM untouched during the reset cycle itself.
        issue_wr = wr_pend_q && !abort && !reset;
        issue_rd = (state_q == RD_ISSUE) && !abort && !reset;

        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        wr_pend_d   = 1'b0;
        wr_last_d   = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        tx_word_d   = tx_word_q;
        tx_valid_d  = tx_valid_q;
        done_c      = 1'b0;
        err_abort_d = err_abort_q && !bus.clr_err;
        err_cmd_d   = err_cmd_q && !bus.clr_err;

        if (abort) begin
            state_d     = IDLE;
            tx_valid_d  = 1'b0;
            err_abort_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.word_valid && bus.cs_active) begin
                        case (cmd_op)
                            OP_WRITE, OP_READ: begin
                                state_d = (cmd_op == OP_WRITE) ? WR_DATA : RD_ISSUE;
                                addr_d  = bus.word_in[ADDR_LO +: ADDR_W];
                                cnt_d   = CNT_W'(bus.word_in[LEN_HI:LEN_LO]) + CNT_W'(1);
                            end
                            OP_ILL:  err_cmd_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
                WR_DATA: begin
                    // The final write issues one cycle after its word arrived;
                    // that issue cycle carries done and closes the burst.
                    if (wr_pend_q && wr_last_q) begin
                        done_c  = 1'b1;
                        state_d = IDLE;
                    end else if (bus.word_valid && (cnt_q != '0)) begin
                        wr_pend_d = 1'b1;
                        wr_last_d = (cnt_q == CNT_W'(1));
                        wr_addr_d = addr_q;
                        wr_data_d = bus.word_in;
                        addr_d    = addr_q + ADDR_W'(1);
                        cnt_d     = cnt_q - CNT_W'(1);
                    end
                end
                RD_ISSUE: state_d = RD_WAIT;
                RD_WAIT: begin
                    tx_word_d  = bus.ram_rdata;
                    tx_valid_d = 1'b1;
                    state_d    = RD_PUSH;
                end
                RD_PUSH: begin
                    if (bus.tx_ready) begin
                        addr_d     = addr_q + ADDR_W'(1);
                        cnt_d      = cnt_q - CNT_W'(1);
                        tx_valid_d = 1'b0;
                        if (cnt_q == CNT_W'(1)) begin
                            done_c  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = RD_ISSUE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            wr_pend_q   <= 1'b0;
            wr_last_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            tx_word_q   <= '0;
            tx_valid_q  <= 1'b0;
            err_abort_q <= 1'b0;
            err_cmd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            wr_pend_q   <= wr_pend_d;
            wr_last_q   <= wr_last_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            tx_word_q   <= tx_word_d;
            tx_valid_q  <= tx_valid_d;
            err_abort_q <= err_abort_d;
            err_cmd_q   <= err_cmd_d;
        end
    end

    assign bus.ram_en    = issue_wr || issue_rd;
    assign bus.ram_we    = issue_wr;
    assign bus.ram_addr  = wr_pend_q ? wr_addr_q : addr_q;
    assign bus.ram_wdata = wr_data_q;
    assign bus.tx_word   = tx_word_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_c && !reset;
    assign bus.err_abort = err_abort_q;
    assign bus.err_cmd   = err_cmd_q;

endmodule

// File: tb/tb_spi_ram_cmd_controller.sv
// Self-checking bench for spi_ram_cmd_controller: directed scenarios plus
// randomized bursts, checked against a word-level model of RAM contents.
module tb_spi_ram_cmd_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_ram_cmd_controller_if #(.ADDR_W(8)) bus();
    spi_ram_cmd_controller #(.ADDR_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    // RAM attached to the DUT; read data appears one cycle after ram_en.
    logic [15:0] ram [256];
    // Reference contents, updated from the burst rules with plain arithmetic.
    logic [15:0] model_mem [256];
    int wr_cnt = 0, done_cnt = 0;
    int exp_wr = 0, exp_done = 0;
    logic [15:0] wq [$];

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata <= ram[bus.ram_addr];
        end
        if (bus.ram_en && bus.ram_we) wr_cnt <= wr_cnt + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // WRITE burst of wq words at start address a; gaps inserts idle cycles.
    task automatic do_write(input logic [7:0] a, input bit gaps);
        int n;
        logic [7:0] ea;
        n = wq.size();
        bus.word_in    = {2'b01, 6'(n - 1), a};
        bus.word_valid = 1'b1;
        cyc();
        bus.word_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.word_valid = 1'b0;
                    cyc();
                end
            end
            bus.word_in    = wq[i];
            bus.word_valid = 1'b1;
            cyc();
            bus.word_valid = 1'b0;
            #1;
            ea = a + 8'(i);
            model_mem[ea] = wq[i];
            chk("wr_en", bus.ram_en, 1);
            chk("wr_we", bus.ram_we, 1);
            chk("wr_addr", bus.ram_addr, ea);
            chk("wr_data", bus.ram_wdata, wq[i]);
            chk("wr_done", bus.done, (i == n - 1));
        end
        exp_wr += n;
        exp_done++;
        cyc();
        #1;
        chk("wr_busy_after", bus.busy, 0);
        chk("wr_count", wr_cnt, exp_wr);
        chk("wr_done_count", done_cnt, exp_done);
    endtask

    // READ burst of n words at a; stall<0 picks random stalls per word.
    task automatic do_read(input logic [7:0] a, input int n, input int stall, input bit dummies);
        int st;
        logic [15:0] exp;
        bus.word_in    = {2'b10, 6'(n - 1), a};
        bus.word_valid = 1'b1;
        cyc();
        bus.word_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp = model_mem[8'(a + 8'(i))];
            for (int k = 0; k < 8; k++) begin
                if (bus.tx_valid) break;
                bus.tx_ready = 1'($urandom_range(0, 1));
                if (dummies) begin
                    bus.word_in    = 16'hC000;
                    bus.word_valid = 1'($urandom_range(0, 1));
                end
                cyc();
            end
            bus.tx_ready = 1'b0;
            chk("rd_valid", bus.tx_valid, 1);
            st = (stall >= 0) ? stall : $urandom_range(0, 3);
            repeat (st) begin
                if (dummies) bus.word_valid = 1'($urandom_range(0, 1));
                #1;
                chk("rd_hold_valid", bus.tx_valid, 1);
                chk("rd_hold_word", bus.tx_word, exp);
                cyc();
            end
            bus.word_valid = 1'b0;
            bus.tx_ready   = 1'b1;
            #1;
            chk("rd_word", bus.tx_word, exp);
            chk("rd_done", bus.done, (i == n - 1));
            cyc();
            bus.tx_ready = 1'b0;
        end
        exp_done++;
        #1;
        chk("rd_valid_drop", bus.tx_valid, 0);
        chk("rd_busy_after", bus.busy, 0);
        chk("rd_err_cmd", bus.err_cmd, 0);
        chk("rd_done_count", done_cnt, exp_done);
        chk("rd_no_writes", wr_cnt, exp_wr);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ram_en"}, bus.ram_en, 0);
        chk({tag, "_ram_we"}, bus.ram_we, 0);
        chk({tag, "_ram_addr"}, bus.ram_addr, 0);
        chk({tag, "_ram_wdata"}, bus.ram_wdata, 0);
        chk({tag, "_tx_word"}, bus.tx_word, 0);
        chk({tag, "_tx_valid"}, bus.tx_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err_abort"}, bus.err_abort, 0);
        chk({tag, "_err_cmd"}, bus.err_cmd, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]       = 16'h0000;
            model_mem[i] = 16'h0000;
        end
        reset          = 1'b1;
        bus.word_in    = '0;
        bus.word_valid = 1'b0;
        bus.cs_active  = 1'b1;
        bus.tx_ready   = 1'b0;
        bus.clr_err    = 1'b0;
        bus.ram_rdata  = '0;
        repeat (3) cyc();
        reset = 1'b0;
        #1;
        chk_reset_outputs("reset");

        // WRITE of 3 words at 0x0A
        wq = '{16'h1111, 16'h2222, 16'h3333};
        do_write(8'h0A, 1'b0);

        // READ of 2 words from 0x0A with a 5-cycle stall per word
        do_read(8'h0A, 2, 5, 1'b0);

        // Address wrap 0xFF -> 0x00
        wq = '{16'hAAAA, 16'hBBBB};
        do_write(8'hFF, 1'b0);

        // Abort: len 4 at 0x10, cs drops with the third word
        bus.word_in = 16'h4310; bus.word_valid = 1'b1; cyc();
        bus.word_in = 16'hA001; cyc();
        bus.word_valid = 1'b0; #1;
        chk("ab_w1_addr", bus.ram_addr, 8'h10);
        chk("ab_w1_en", bus.ram_en, 1);
        model_mem[8'h10] = 16'hA001;
        cyc();
        bus.word_in = 16'hA002; bus.word_valid = 1'b1; cyc();
        bus.word_valid = 1'b0; #1;
        chk("ab_w2_addr", bus.ram_addr, 8'h11);
        chk("ab_w2_en", bus.ram_en, 1);
        model_mem[8'h11] = 16'hA002;
        cyc();
        bus.word_in = 16'hA003; bus.word_valid = 1'b1; bus.cs_active = 1'b0; #1;
        chk("ab_cycle_en", bus.ram_en, 0);
        chk("ab_cycle_done", bus.done, 0);
        cyc();
        bus.word_valid = 1'b0; bus.cs_active = 1'b1; #1;
        exp_wr += 2;
        chk("ab_err", bus.err_abort, 1);
        chk("ab_busy", bus.busy, 0);
        chk("ab_en", bus.ram_en, 0);
        chk("ab_writes", wr_cnt, exp_wr);
        chk("ab_no_done", done_cnt, exp_done);
        bus.clr_err = 1'b1; cyc();
        bus.clr_err = 1'b0; #1;
        chk("ab_clr", bus.err_abort, 0);

        // Registered write suppressed by cs loss in its issue cycle
        bus.word_in = 16'h4120; bus.word_valid = 1'b1; cyc();
        bus.word_in = 16'hB001; cyc();
        bus.word_valid = 1'b0; bus.cs_active = 1'b0; #1;
        chk("sup_en", bus.ram_en, 0);
        cyc();
        bus.cs_active = 1'b1; #1;
        chk("sup_busy", bus.busy, 0);
        chk("sup_err", bus.err_abort, 1);
        chk("sup_writes", wr_cnt, exp_wr);
        bus.clr_err = 1'b1; cyc();
        bus.clr_err = 1'b0;

        // Illegal op then NOP
        bus.word_in = 16'hC000; bus.word_valid = 1'b1; cyc();
        bus.word_in = 16'h0000; #1;
        chk("ill_err", bus.err_cmd, 1);
        chk("ill_busy", bus.busy, 0);
        cyc();
        bus.word_valid = 1'b0; #1;
        chk("nop_busy", bus.busy, 0);
        chk("nop_en", bus.ram_en, 0);
        chk("nop_err_kept", bus.err_cmd, 1);
        // New error in the same cycle as clr_err keeps the flag set
        bus.clr_err = 1'b1; bus.word_in = 16'hC000; bus.word_valid = 1'b1; cyc();
        bus.clr_err = 1'b0; bus.word_valid = 1'b0; #1;
        chk("ill_set_wins", bus.err_cmd, 1);
        bus.clr_err = 1'b1; cyc();
        bus.clr_err = 1'b0; #1;
        chk("ill_clr", bus.err_cmd, 0);
        chk("ill_writes", wr_cnt, exp_wr);
        // Command with chip-select inactive is ignored
        bus.cs_active = 1'b0; bus.word_in = 16'h4100; bus.word_valid = 1'b1; cyc();
        bus.word_valid = 1'b0; bus.cs_active = 1'b1; #1;
        chk("nocs_busy", bus.busy, 0);

        // Randomized bursts
        for (int t = 0; t < 10; t++) begin
            logic [7:0] a;
            int n;
            a = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 1) begin
                wq = {};
                for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
                do_write(a, 1'b1);
            end else begin
                do_read(a, n, -1, 1'b1);
            end
        end
        do_read(8'hFF, 2, -1, 1'b1);

        // Back-to-back write, then reset during a read
        wq = '{16'h5A5A, 16'hA5A5};
        do_write(8'h30, 1'b0);
        bus.word_in = 16'h8130; bus.word_valid = 1'b1; cyc();
        bus.word_valid = 1'b0; reset = 1'b1; #1;
        chk("rst_cycle_en", bus.ram_en, 0);
        cyc();
        reset = 1'b0; #1;
        chk_reset_outputs("rst_mid");
        cyc(); #1;
        chk("rst_after_en", bus.ram_en, 0);
        chk("rst_after_tx", bus.tx_valid, 0);
        chk("rst_writes", wr_cnt, exp_wr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_ram_cmd_controller.md
Name: spi_ram_cmd_controller

Overview:
- Command sequencer between the SPI word deserializer and the on-chip RAM.
- Consumes 16-bit words (`word_in` / `word_valid`) already in the `clk` domain and decodes a command word.
- Performs burst writes or burst reads on a single-port synchronous RAM.
- Hands read data to the SPI transmit shifter through a valid/ready handshake.
- Reports framing and command errors.

Parameters:
- ADDR_W, 8, RAM address width (1..8); taken from cmd[7:0], upper bits ignored when ADDR_W<8.
- DATA_W, 16, word width; fixed to 16 by the frame format.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- word_in  in  16  deserialized word; valid only with word_valid
- word_valid  in  1  single-cycle pulse, one per received word
- cs_active  in  1  synchronized chip-select level; 1 = frame in progress
- ram_en  out  1  RAM access strobe, one cycle per access
- ram_we  out  1  1 = write, 0 = read; qualified by ram_en
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  16  RAM write data
- ram_rdata  in  16  RAM read data, valid exactly 1 cycle after a read ram_en
- tx_word  out  16  word for the SPI transmit shifter
- tx_valid  out  1  tx_word valid; held until tx_ready
- tx_ready  in  1  shifter accepts tx_word this cycle
- busy  out  1  1 whenever state != IDLE
- done  out  1  one-cycle pulse when a burst completes its final word
- err_abort  out  1  sticky: cs dropped mid-burst
- err_cmd  out  1  sticky: illegal opcode received
- clr_err  in  1  clears both sticky flags

Behaviour:
- Reset: state=IDLE; all outputs 0; addr/count registers 0.
- Command word (first word_valid in IDLE while cs_active=1):
  - [15:14] op: 00 NOP, 01 WRITE, 10 READ, 11 illegal.
  - [13:8] len-1, so 1..64 words.
  - [7:0] start address.
- States: IDLE, WR_DATA, RD_ISSUE, RD_WAIT, RD_PUSH.
- IDLE:
  - op=01 -> WR_DATA; load addr and remaining count = len.
  - op=10 -> RD_ISSUE; load addr and remaining count = len.
  - op=00 -> stay in IDLE, no effect.
  - op=11 -> set err_cmd, stay in IDLE.
- WR_DATA:
  - On word_valid, register the write. In the next cycle: ram_en=1, ram_we=1, ram_addr=addr, ram_wdata=word. Latency is 1 cycle.
  - addr increments modulo 2^ADDR_W; count decrements.
  - On the last word: done pulses in the same cycle as the final ram_en, then -> IDLE.
  - word_valid on consecutive cycles must be fully supported, with no drops.
- RD_ISSUE: ram_en=1, ram_we=0 for one cycle -> RD_WAIT.
- RD_WAIT: capture ram_rdata into tx_word; assert tx_valid -> RD_PUSH.
- RD_PUSH:
  - Hold tx_word and tx_valid stable until tx_ready=1.
  - On accept: addr++ (wrapping), count--.
  - Last word: done pulses, tx_valid drops, -> IDLE. Otherwise -> RD_ISSUE.
  - Read throughput is at most one word per 3 cycles.
- word_valid during any RD_* state (dummy clocking words) is ignored.
- tx_ready while tx_valid=0 is ignored.
- Abort: cs_active=0 in any non-IDLE state forces IDLE next cycle.
  - Set err_abort; no done pulse; drop tx_valid.
  - Suppress any registered but not-yet-issued write.
  - Abort wins over a word_valid in the same cycle; that word is discarded.
- word_valid with cs_active=0 in IDLE is ignored.
- clr_err:
  - Clears both flags next cycle.
  - If a new error occurs in the same cycle, setting wins.
- Reset mid-burst: IDLE immediately; no RAM access in the reset cycle or after it.

Decomposition:
- Package spi_ram_pkg holds:
  - op encodings OP_NOP/OP_WRITE/OP_READ/OP_ILL.
  - command field bit positions (OP_HI=15, OP_LO=14, LEN_HI=13, LEN_LO=8, ADDR_HI=7, ADDR_LO=0).
  - state enum constants.
  - MAX_LEN=64.
- Single module; no sub-module needed. The address/count logic stays inline.

Test Plan:
- WRITE of 3 words: cmd 0x420A, then 0x1111, 0x2222, 0x3333.
  - Expect writes to addr 0x0A/0x0B/0x0C with matching data, each 1 cycle after its word_valid.
  - done with the third write; busy drops the cycle after.
- READ of 2 words: preload 0x0A=0x1111, 0x0B=0x2222; send cmd 0x810A; tx_ready stalled 5 cycles.
  - Expect tx_word=0x1111 held stable through the stall, then 0x2222.
  - done on the second accept.
- Address wrap: WRITE cmd 0x41FF with data 0xAAAA, 0xBBBB.
  - Expect writes to 0xFF then 0x00.
- Abort: WRITE cmd with len=4 (0x4310); send 2 data words, drop cs_active together with the third word_valid.
  - Expect exactly 2 writes, err_abort=1, no done, state IDLE.
  - After clr_err, err_abort=0.
- Illegal op: cmd 0xC000, then cmd 0x0000.
  - Expect err_cmd=1, no ram_en, busy stays 0.
- Back-to-back: WRITE len=2 with word_valid on consecutive cycles, then reset asserted during a READ.
  - Expect two writes on consecutive cycles.
  - After reset: all outputs 0, no ram_en.
